pcs_pma_conf_ctrl: RTL and testbench

PCS_PMA_CONF_CTRL -- requirements
Module: pcs_pma_conf_ctrl

---
 rtl/pcs_pma_conf_ctrl.sv | 155 +++++++++++++++
 tb/tb_pcs_pma_conf_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcs_pma_conf_ctrl.sv
// Per-channel 10GBASE-R bring-up sequencer driving the PCS/PMA configuration vector.
// Each channel owns one down-counting timer, reused for the pulse, lock-timeout and status periods.
//
//   state     | meaning
//   RESET_PMA | PMA reset pulse, TX disabled
//   RESET_PCS | PCS reset pulse, TX disabled
//   WAIT_LOCK | waiting for block lock, timeout retries bring-up
//   CLEAR     | one-cycle link-status set / fault clear
//   RUN       | channel up, periodic status-counter clear pulses
module pcs_pma_conf_ctrl #(
   parameter int NUM_CH       = 2,
   parameter int PULSE_CYCLES = 16,
   parameter int LOCK_TIMEOUT = 65536,
   parameter int STAT_PERIOD  = 1024,
   localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cfg_wr,
   input  logic [CHW-1:0]        cfg_ch,
   input  logic                  cfg_loopback,
   input  logic                  cfg_tx_disable,
   input  logic                  cfg_restart,
   input  logic [NUM_CH-1:0]     block_lock,
   output logic [NUM_CH*536-1:0] pcs_pma_configuration_vector,
   output logic [NUM_CH-1:0]     ch_up,
   output logic [NUM_CH*3-1:0]   ch_state,
   output logic [NUM_CH*8-1:0]   ch_retry_cnt
);

   localparam int TMAX0 = (PULSE_CYCLES > LOCK_TIMEOUT) ? PULSE_CYCLES : LOCK_TIMEOUT;
   localparam int TMAX  = (TMAX0 > STAT_PERIOD) ? TMAX0 : STAT_PERIOD;
   localparam int TW    = $clog2(TMAX);

   localparam logic [TW-1:0] PULSE_LD = TW'(PULSE_CYCLES - 1);
   localparam logic [TW-1:0] LOCK_LD  = TW'(LOCK_TIMEOUT - 1);
   localparam logic [TW-1:0] STAT_LD  = TW'(STAT_PERIOD - 1);

   typedef enum logic [2:0] {
      RESET_PMA = 3'd0,
      RESET_PCS = 3'd1,
      WAIT_LOCK = 3'd2,
      CLEAR     = 3'd3,
      RUN       = 3'd4
   } state_e;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      state_e         state_q, state_d;
      logic [TW-1:0]  tmr_q, tmr_d;
      logic [7:0]     retry_q, retry_d;
      logic           lb_q, txd_q;
      logic           sel;
      logic [535:0]   vec;

      assign sel = cfg_wr && (int'(cfg_ch) == c);

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_q <= RESET_PMA;
            tmr_q   <= PULSE_LD;
            retry_q <= 8'd0;
            lb_q    <= 1'b0;
            txd_q   <= 1'b0;
         end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            retry_q <= retry_d;
            if (sel) begin
               lb_q  <= cfg_loopback;
               txd_q <= cfg_tx_disable;
            end
         end
      end

      // Restart has priority over every state-local event, including timeout and lock.
      always_comb begin
         state_d = state_q;
         tmr_d   = tmr_q;
         retry_d = retry_q;
         if (sel && cfg_restart) begin
            state_d = RESET_PMA;
            tmr_d   = PULSE_LD;
         end else begin
            case (state_q)
               RESET_PMA: begin
                  if (tmr_q == '0) begin
                     state_d = RESET_PCS;
                     tmr_d   = PULSE_LD;
                  end else begin
                     tmr_d = tmr_q - 1'b1;
                  end
               end
               RESET_PCS: begin
                  if (tmr_q == '0) begin
                     state_d = WAIT_LOCK;
                     tmr_d   = LOCK_LD;
                  end else begin
                     tmr_d = tmr_q - 1'b1;
                  end
               end
               WAIT_LOCK: begin
                  if (block_lock[c]) begin
                     state_d = CLEAR;
                  end else if (tmr_q == '0) begin
                     state_d = RESET_PMA;
                     tmr_d   = PULSE_LD;
                     if (retry_q != 8'hFF) retry_d = retry_q + 8'd1;
                  end else begin
                     tmr_d = tmr_q - 1'b1;
                  end
               end
               CLEAR: begin
                  state_d = RUN;
                  tmr_d   = STAT_LD;
               end
               RUN: begin
                  if (!block_lock[c]) begin
                     state_d = WAIT_LOCK;
                     tmr_d   = LOCK_LD;
                  end else if (tmr_q == '0) begin
                     tmr_d = STAT_LD;
                  end else begin
                     tmr_d = tmr_q - 1'b1;
                  end
               end
               default: begin
                  state_d = RESET_PMA;
                  tmr_d   = PULSE_LD;
               end
            endcase
         end
      end

      always_comb begin
         vec      = '0;
         vec[0]   = lb_q;
         vec[15]  = (state_q == RESET_PMA);
         vec[16]  = txd_q || (state_q == RESET_PMA) || (state_q == RESET_PCS);
         vec[110] = lb_q;
         vec[111] = (state_q == RESET_PCS);
         vec[512] = (state_q == CLEAR);
         vec[513] = (state_q == CLEAR);
         vec[516] = (state_q == CLEAR);
         vec[517] = (state_q == CLEAR);
         vec[518] = (state_q == RUN) && (tmr_q == '0);
         vec[519] = (state_q == RUN) && (tmr_q == '0);
      end

      assign pcs_pma_configuration_vector[c*536 +: 536] = vec;
      assign ch_up[c]                = (state_q == RUN);
      assign ch_state[c*3 +: 3]      = state_q;
      assign ch_retry_cnt[c*8 +: 8]  = retry_q;
   end

endmodule

// File: tb/tb_pcs_pma_conf_ctrl.sv
// Directed bench for pcs_pma_conf_ctrl: bring-up, status pulses, timeout/retry, restart, config, reset.
// Three channels so a 2-bit cfg_ch can address a non-existent channel.
module tb_pcs_pma_conf_ctrl;
   localparam int NCH = 3;
   localparam int VW  = 536;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic cfg_wr = 1'b0, cfg_loopback = 1'b0, cfg_tx_disable = 1'b0, cfg_restart = 1'b0;
   logic [1:0] cfg_ch = 2'd0;
   logic [NCH-1:0] block_lock = '0;
   logic [NCH*VW-1:0] vec;
   logic [NCH-1:0] ch_up;
   logic [NCH*3-1:0] ch_state;
   logic [NCH*8-1:0] ch_retry_cnt;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   pcs_pma_conf_ctrl #(
      .NUM_CH(NCH), .PULSE_CYCLES(4), .LOCK_TIMEOUT(8), .STAT_PERIOD(4)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_loopback(cfg_loopback),
      .cfg_tx_disable(cfg_tx_disable), .cfg_restart(cfg_restart),
      .block_lock(block_lock),
      .pcs_pma_configuration_vector(vec),
      .ch_up(ch_up), .ch_state(ch_state), .ch_retry_cnt(ch_retry_cnt)
   );

   function automatic logic [2:0] st(int c);
      return ch_state[c*3 +: 3];
   endfunction
   function automatic logic vb(int c, int b);
      return vec[c*VW + b];
   endfunction
   function automatic logic [7:0] rc(int c);
      return ch_retry_cnt[c*8 +: 8];
   endfunction

   task automatic test_reset();
      logic [NCH*VW-1:0] ev;
      #1;
      ev = '0;
      for (int c = 0; c < NCH; c++) begin
         ev[c*VW+15] = 1'b1;
         ev[c*VW+16] = 1'b1;
         tests++;
         if (st(c) !== 3'd0) begin
            fails++; $display("FAIL reset_state ch%0d got %0d exp 0", c, st(c));
         end
      end
      tests++;
      if (vec !== ev) begin
         fails++; $display("FAIL reset_vector %0d bits differ from expected", $countones(vec ^ ev));
      end
      tests++;
      if (ch_up !== 3'b000) begin
         fails++; $display("FAIL reset_ch_up got %b exp 000", ch_up);
      end
      tests++;
      if (ch_retry_cnt !== '0) begin
         fails++; $display("FAIL reset_retry got %h exp 0", ch_retry_cnt);
      end
   endtask

   task automatic test_bringup();
      logic [2:0] e;
      logic [VW-1:0] es;
      block_lock = 3'b111;
      @(negedge clk);
      rst_n = 1'b1;
      tests++;
      if (st(0) !== 3'd0 || vb(0, 15) !== 1'b1) begin
         fails++; $display("FAIL bringup_release state %0d bit15 %b exp 0/1", st(0), vb(0, 15));
      end
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         e = (i <= 3) ? 3'd0 : (i <= 7) ? 3'd1 : (i == 8) ? 3'd2 : (i == 9) ? 3'd3 : 3'd4;
         tests++;
         if (st(0) !== e || st(1) !== e) begin
            fails++; $display("FAIL bringup_state cyc%0d got %0d/%0d exp %0d", i, st(0), st(1), e);
         end
         tests++;
         if (vb(0, 15) !== (e == 3'd0) || vb(1, 111) !== (e == 3'd1) || vb(0, 16) !== (e <= 3'd1)) begin
            fails++; $display("FAIL bringup_rst_bits cyc%0d got b15=%b b111=%b b16=%b state_exp %0d",
                              i, vb(0, 15), vb(1, 111), vb(0, 16), e);
         end
         tests++;
         if ({vb(0, 512), vb(0, 513), vb(0, 516), vb(0, 517)} !== {4{e == 3'd3}}) begin
            fails++; $display("FAIL bringup_clear_bits cyc%0d got %b exp %b", i,
                              {vb(0, 512), vb(0, 513), vb(0, 516), vb(0, 517)}, {4{e == 3'd3}});
         end
         tests++;
         if (ch_up !== ((e == 3'd4) ? 3'b111 : 3'b000)) begin
            fails++; $display("FAIL bringup_ch_up cyc%0d got %b", i, ch_up);
         end
         if (i == 9) begin
            es = '0;
            es[512] = 1'b1; es[513] = 1'b1; es[516] = 1'b1; es[517] = 1'b1;
            tests++;
            if (vec[VW-1:0] !== es) begin
               fails++; $display("FAIL bringup_clear_slice %0d bits differ", $countones(vec[VW-1:0] ^ es));
            end
         end
      end
   endtask

   task automatic test_stat();
      for (int k = 1; k <= 12; k++) begin
         if (k > 1) @(negedge clk);
         tests++;
         if (vb(0, 518) !== (k % 4 == 0) || vb(0, 519) !== (k % 4 == 0) || vb(1, 518) !== (k % 4 == 0)) begin
            fails++; $display("FAIL stat_pulse run_cyc%0d got %b%b%b exp %b", k,
                              vb(0, 518), vb(0, 519), vb(1, 518), (k % 4 == 0));
         end
      end
      block_lock[0] = 1'b0;
      @(negedge clk);
      tests++;
      if (st(0) !== 3'd2 || ch_up[0] !== 1'b0) begin
         fails++; $display("FAIL stat_lock_drop got state %0d up %b exp 2/0", st(0), ch_up[0]);
      end
      block_lock[0] = 1'b1;
      @(negedge clk);
      tests++;
      if (st(0) !== 3'd3) begin
         fails++; $display("FAIL stat_relock got state %0d exp 3", st(0));
      end
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         tests++;
         if (st(0) !== 3'd4 || vb(0, 518) !== (k == 4)) begin
            fails++; $display("FAIL stat_reentry run_cyc%0d got state %0d b518 %b exp 4/%b",
                              k, st(0), vb(0, 518), (k == 4));
         end
      end
   endtask

   task automatic test_timeout();
      block_lock[1] = 1'b0;
      for (int n = 1; n <= 8; n++) begin
         @(negedge clk);
         tests++;
         if (st(1) !== 3'd2 || st(0) !== 3'd4) begin
            fails++; $display("FAIL timeout_wait n%0d got ch1 %0d ch0 %0d exp 2/4", n, st(1), st(0));
         end
      end
      @(negedge clk);
      tests++;
      if (st(1) !== 3'd0 || vb(1, 15) !== 1'b1) begin
         fails++; $display("FAIL timeout_fire got state %0d b15 %b exp 0/1", st(1), vb(1, 15));
      end
      tests++;
      if (rc(1) !== 8'd1 || rc(0) !== 8'd0 || st(0) !== 3'd4) begin
         fails++; $display("FAIL timeout_retry got ch1 %0d ch0 %0d ch0_state %0d exp 1/0/4", rc(1), rc(0), st(0));
      end
   endtask

   task automatic test_restart_in_pma();
      @(negedge clk);
      tests++;
      if (st(1) !== 3'd0) begin
         fails++; $display("FAIL rpma_pre got %0d exp 0", st(1));
      end
      cfg_wr = 1'b1; cfg_ch = 2'd1; cfg_restart = 1'b1;
      @(negedge clk);
      cfg_wr = 1'b0; cfg_restart = 1'b0;
      for (int n = 1; n <= 5; n++) begin
         if (n > 1) @(negedge clk);
         tests++;
         if (st(1) !== ((n <= 4) ? 3'd0 : 3'd1)) begin
            fails++; $display("FAIL rpma_count n%0d got %0d exp %0d", n, st(1), (n <= 4) ? 0 : 1);
         end
      end
   endtask

   task automatic test_restart_at_timeout();
      int n;
      n = 0;
      while (st(1) !== 3'd2 && n < 20) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (st(1) !== 3'd2) begin
         fails++; $display("FAIL rto_reach_wait got %0d exp 2", st(1));
      end
      for (int k = 2; k <= 8; k++) begin
         @(negedge clk);
         tests++;
         if (st(1) !== 3'd2) begin
            fails++; $display("FAIL rto_wait k%0d got %0d exp 2", k, st(1));
         end
      end
      cfg_wr = 1'b1; cfg_ch = 2'd1; cfg_restart = 1'b1;
      @(negedge clk);
      cfg_wr = 1'b0; cfg_restart = 1'b0;
      tests++;
      if (st(1) !== 3'd0 || rc(1) !== 8'd1) begin
         fails++; $display("FAIL rto_result got state %0d retry %0d exp 0/1", st(1), rc(1));
      end
   endtask

   task automatic test_config();
      cfg_wr = 1'b1; cfg_ch = 2'd1; cfg_loopback = 1'b1; cfg_tx_disable = 1'b0;
      @(negedge clk);
      cfg_wr = 1'b0;
      tests++;
      if (vb(1, 0) !== 1'b1 || vb(1, 110) !== 1'b1) begin
         fails++; $display("FAIL cfg_lb_ch1 got b0 %b b110 %b exp 1/1", vb(1, 0), vb(1, 110));
      end
      tests++;
      if (vb(0, 0) !== 1'b0 || vb(2, 0) !== 1'b0) begin
         fails++; $display("FAIL cfg_lb_other got ch0 %b ch2 %b exp 0/0", vb(0, 0), vb(2, 0));
      end
      cfg_wr = 1'b1; cfg_ch = 2'd3; cfg_loopback = 1'b1; cfg_tx_disable = 1'b1; cfg_restart = 1'b1;
      @(negedge clk);
      cfg_wr = 1'b0; cfg_restart = 1'b0;
      tests++;
      if (vb(0, 0) !== 1'b0 || vb(0, 16) !== 1'b0 || vb(2, 0) !== 1'b0 || vb(2, 16) !== 1'b0 ||
          vb(1, 0) !== 1'b1 || st(0) !== 3'd4 || st(2) !== 3'd4) begin
         fails++; $display("FAIL cfg_bad_ch got ch0 %b%b ch2 %b%b ch1 %b states %0d/%0d exp 00/00/1/4/4",
                           vb(0, 0), vb(0, 16), vb(2, 0), vb(2, 16), vb(1, 0), st(0), st(2));
      end
      cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_loopback = 1'b0; cfg_tx_disable = 1'b1;
      @(negedge clk);
      cfg_wr = 1'b0;
      tests++;
      if (vb(0, 16) !== 1'b1 || vb(0, 0) !== 1'b0 || st(0) !== 3'd4) begin
         fails++; $display("FAIL cfg_txdis_set got b16 %b b0 %b state %0d exp 1/0/4", vb(0, 16), vb(0, 0), st(0));
      end
      cfg_wr = 1'b1; cfg_tx_disable = 1'b0;
      @(negedge clk);
      cfg_wr = 1'b0;
      tests++;
      if (vb(0, 16) !== 1'b0) begin
         fails++; $display("FAIL cfg_txdis_clr got %b exp 0", vb(0, 16));
      end
   endtask

   task automatic test_saturation();
      for (int n = 0; n < 6000 && rc(1) !== 8'd255; n++) @(negedge clk);
      tests++;
      if (rc(1) !== 8'd255) begin
         fails++; $display("FAIL sat_reach got %0d exp 255", rc(1));
      end
      repeat (40) @(negedge clk);
      tests++;
      if (rc(1) !== 8'd255 || rc(0) !== 8'd0) begin
         fails++; $display("FAIL sat_hold got ch1 %0d ch0 %0d exp 255/0", rc(1), rc(0));
      end
   endtask

   task automatic test_mid_reset();
      tests++;
      if (ch_up[0] !== 1'b1) begin
         fails++; $display("FAIL mreset_pre got ch_up0 %b exp 1", ch_up[0]);
      end
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      tests++;
      if (ch_up !== 3'b000) begin
         fails++; $display("FAIL mreset_ch_up got %b exp 000", ch_up);
      end
      for (int c = 0; c < NCH; c++) begin
         tests++;
         if (st(c) !== 3'd0 || vb(c, 15) !== 1'b1 || vb(c, 16) !== 1'b1 || vb(c, 0) !== 1'b0 || rc(c) !== 8'd0) begin
            fails++; $display("FAIL mreset_ch%0d got state %0d b15 %b b16 %b b0 %b retry %0d exp 0/1/1/0/0",
                              c, st(c), vb(c, 15), vb(c, 16), vb(c, 0), rc(c));
         end
      end
      #4;
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_bringup();
      test_stat();
      test_timeout();
      test_restart_in_pma();
      test_restart_at_timeout();
      test_config();
      test_saturation();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
